// File: rtl/mem_resp_mc.sv
// Single-port memory responder: one request at a time through IDLE/WAIT/ACCESS/RESP, response WAIT_CYCLES+1 edges after acceptance.
// No queuing: req_ready is high only in IDLE, and the one-cycle rsp_valid pulse cannot be stalled.
module mem_resp_mc #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  state
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      st, st_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept, commit, err;
    logic        l_wr, l_uns;
    logic [31:0] l_addr, l_wdata;
    logic [1:0]  l_size;
    logic [AW-1:0] idx;
    logic [31:0] word, wlane, ld_data;
    logic [3:0]  be;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    logic [31:0] mem [DEPTH_WORDS];

    assign state     = st;
    assign req_ready = (st == IDLE);
    assign busy      = (st != IDLE);
    assign accept    = (st == IDLE) && req_valid;
    assign idx       = l_addr[AW+1:2];
    assign word      = mem[idx];

    always_comb begin
        err = 1'b0;
        if (l_size == 2'b11)                                err = 1'b1;
        if (l_size == 2'b01 && l_addr[0])                   err = 1'b1;
        if (l_size == 2'b10 && l_addr[1:0] != 2'b00)        err = 1'b1;
        if ({2'b00, l_addr[31:2]} >= 32'(DEPTH_WORDS))      err = 1'b1;
    end

    assign commit = (st == ACCESS) && l_wr && !err;

    // Store data is replicated across lanes so the byte enables alone select what lands.
    always_comb begin
        be    = 4'b1111;
        wlane = l_wdata;
        case (l_size)
            2'b00: begin
                be    = 4'b0001 << l_addr[1:0];
                wlane = {4{l_wdata[7:0]}};
            end
            2'b01: begin
                be    = l_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{l_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_byte = word[{l_addr[1:0], 3'b000} +: 8];
        rd_half = l_addr[1] ? word[31:16] : word[15:0];
        case (l_size)
            2'b00:   ld_data = l_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   ld_data = l_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_data = word;
        endcase
    end

    always_comb begin
        st_next  = st;
        cnt_next = cnt;
        case (st)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        st_next  = WAIT;
                        cnt_next = 4'(WAIT_CYCLES);
                    end else begin
                        st_next = ACCESS;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) st_next = ACCESS;
            end
            ACCESS:  st_next = RESP;
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            l_wr      <= 1'b0;
            l_uns     <= 1'b0;
            l_addr    <= 32'd0;
            l_wdata   <= 32'd0;
            l_size    <= 2'b00;
        end else begin
            st        <= st_next;
            cnt       <= cnt_next;
            rsp_valid <= (st == ACCESS);
            if (accept) begin
                l_wr    <= req_wr;
                l_uns   <= req_unsigned;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_size  <= req_size;
            end
            if (st == ACCESS) begin
                rsp_err   <= err;
                rsp_rdata <= (err || l_wr) ? 32'd0 : ld_data;
            end
        end
    end

    // Array is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_resp_mc.sv
// Directed bench for mem_resp_mc: one instance with 2 wait states, one with none.
module tb_mem_resp_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid_z = 1'b0;
    logic        req_wr = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [1:0]  req_size = 2'b10;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  state;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;
    logic [1:0]  z_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_resp_mc #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .state(state)
    );

    mem_resp_mc #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_ready(z_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .busy(z_busy), .state(z_state)
    );

    // Issues one request to the 2-wait instance, scrambles the inputs after acceptance,
    // and reports the response latency (negedges after the accepting edge) and pulse width.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic un,
                          output logic [31:0] rd, output logic er, output int lat, output int wid);
        int n;
        lat = -1; wid = 0; rd = 'x; er = 1'bx;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
        req_size = sz; req_unsigned = un;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_wr = ~wr; req_addr = ~addr; req_wdata = ~wd;
        req_size = 2'b11; req_unsigned = ~un;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) begin
                if (lat < 0) begin lat = k; rd = rsp_rdata; er = rsp_err; end
                wid++;
            end else if (lat >= 0) begin
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({state, busy, req_ready, rsp_valid, rsp_err, rsp_rdata} !== {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0})
            begin errors++; $display("FAIL reset_w2: st=%0d busy=%b rdy=%b vld=%b err=%b rd=%h", state, busy, req_ready, rsp_valid, rsp_err, rsp_rdata); end
        checks++;
        if ({z_state, z_busy, z_req_ready, z_rsp_valid} !== {2'd0, 1'b0, 1'b1, 1'b0})
            begin errors++; $display("FAIL reset_w0: st=%0d busy=%b rdy=%b vld=%b", z_state, z_busy, z_req_ready, z_rsp_valid); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int lat, wid;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat, wid);
        checks++;
        if (lat !== 3 || wid !== 1 || er !== 1'b0 || rd !== 32'd0)
            begin errors++; $display("FAIL store_word: lat=%0d wid=%0d err=%b rd=%h, want lat=3 wid=1 err=0 rd=0", lat, wid, er, rd); end
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, wid);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF)
            begin errors++; $display("FAIL load_word: lat=%0d err=%b rd=%h, want lat=3 err=0 rd=deadbeef", lat, er, rd); end
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL rdata_hold: rd=%h vld=%b, want deadbeef 0", rsp_rdata, rsp_valid); end
    endtask

    task automatic test_byte_half;
        logic        t_wr [10]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic [31:0] t_ad [10]  = '{32'h11, 32'h11, 32'h11, 32'h10, 32'h12, 32'h12, 32'h10, 32'h10, 32'h13, 32'h13};
        logic [31:0] t_wd [10]  = '{32'hFFFFFF80, 0, 0, 0, 32'h1234CAFE, 0, 0, 0, 0, 0};
        logic [1:0]  t_sz [10]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
        logic        t_un [10]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 1};
        logic [31:0] t_exp [10] = '{32'h0, 32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF, 32'h0,
                                    32'hFFFFCAFE, 32'h000080EF, 32'hCAFE80EF, 32'hFFFFFFCA, 32'h000000CA};
        logic [31:0] rd; logic er; int lat, wid;
        for (int i = 0; i < 10; i++) begin
            do_req(t_wr[i], t_ad[i], t_wd[i], t_sz[i], t_un[i], rd, er, lat, wid);
            checks++;
            if (lat !== 3 || er !== 1'b0 || rd !== t_exp[i])
                begin errors++; $display("FAIL subword[%0d]: lat=%0d err=%b rd=%h, want lat=3 err=0 rd=%h", i, lat, er, rd, t_exp[i]); end
        end
    endtask

    task automatic test_errors;
        logic        t_wr [3] = '{0, 1, 1};
        logic [31:0] t_ad [3] = '{32'h13, 32'h12, 32'h10};
        logic [1:0]  t_sz [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] rd; logic er; int lat, wid;
        for (int i = 0; i < 3; i++) begin
            do_req(t_wr[i], t_ad[i], 32'h55555555, t_sz[i], 1'b0, rd, er, lat, wid);
            checks++;
            if (lat !== 3 || wid !== 1 || er !== 1'b1 || rd !== 32'd0)
                begin errors++; $display("FAIL err_req[%0d]: lat=%0d wid=%0d err=%b rd=%h, want lat=3 wid=1 err=1 rd=0", i, lat, wid, er, rd); end
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat, wid);
        checks++;
        if (er !== 1'b0 || rd !== 32'hCAFE80EF)
            begin errors++; $display("FAIL err_nowrite: err=%b rd=%h, want err=0 rd=cafe80ef", er, rd); end
    endtask

    task automatic test_range;
        logic [31:0] rd; logic er; int lat, wid;
        do_req(1'b1, 32'h3FC, 32'hA5A5A5A5, 2'b10, 1'b0, rd, er, lat, wid);
        do_req(1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, rd, er, lat, wid);
        checks++;
        if (er !== 1'b0 || rd !== 32'hA5A5A5A5)
            begin errors++; $display("FAIL range_last: err=%b rd=%h, want err=0 rd=a5a5a5a5", er, rd); end
        do_req(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, rd, er, lat, wid);
        checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 32'd0)
            begin errors++; $display("FAIL range_over: lat=%0d err=%b rd=%h, want lat=3 err=1 rd=0", lat, er, rd); end
        do_req(1'b1, 32'hFFFFFFFC, 32'h12345678, 2'b10, 1'b0, rd, er, lat, wid);
        checks++;
        if (er !== 1'b1)
            begin errors++; $display("FAIL range_top: err=%b, want 1", er); end
    endtask

    task automatic test_back_to_back;
        int acc, rsp, prev, bad_gap, n;
        acc = 0; rsp = 0; prev = -1; bad_gap = 0;
        req_wr = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (rsp_valid) begin
                rsp++;
                if (rsp_rdata !== 32'hCAFE80EF) bad_gap++;
            end
            if (req_ready) begin
                if (prev >= 0 && k - prev != 5) bad_gap++;
                prev = k;
                acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (acc !== 5 || rsp !== 5 || bad_gap !== 0)
            begin errors++; $display("FAIL back_to_back: accepts=%0d rsps=%0d bad=%0d, want 5 5 0", acc, rsp, bad_gap); end
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic er; int lat, wid;
        do_req(1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, rd, er, lat, wid);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_size = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (state !== 2'd1 || busy !== 1'b1 || req_ready !== 1'b0)
            begin errors++; $display("FAIL busy_in_wait: st=%0d busy=%b rdy=%b, want 1 1 0", state, busy, req_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({state, busy, req_ready, rsp_valid} !== {2'd0, 1'b0, 1'b1, 1'b0})
            begin errors++; $display("FAIL abort_reset: st=%0d busy=%b rdy=%b vld=%b, want 0 0 1 0", state, busy, req_ready, rsp_valid); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat, wid);
        checks++;
        if (lat !== 3 || wid !== 1 || rd !== 32'h11111111)
            begin errors++; $display("FAIL abort_nowrite: lat=%0d wid=%0d rd=%h, want 3 1 11111111", lat, wid, rd); end
    endtask

    task automatic test_reset_in_resp;
        int n;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_size = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 1'b1)
            begin errors++; $display("FAIL resp_reached: vld=%b after %0d cycles, want 1", rsp_valid, n); end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || state !== 2'd0)
            begin errors++; $display("FAIL reset_in_resp: vld=%b st=%0d, want 0 0", rsp_valid, state); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait;
        logic        t_wr [2]  = '{1, 0};
        logic [31:0] t_exp [2] = '{32'h0, 32'h0BADF00D};
        for (int i = 0; i < 2; i++) begin
            req_valid_z = 1'b1; req_wr = t_wr[i]; req_addr = 32'h10;
            req_wdata = 32'h0BADF00D; req_size = 2'b10; req_unsigned = 1'b0;
            @(posedge clk);
            @(negedge clk);
            req_valid_z = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wr = ~t_wr[i];
            checks++;
            if (z_state !== 2'd2 || z_rsp_valid !== 1'b0)
                begin errors++; $display("FAIL zw_access[%0d]: st=%0d vld=%b, want 2 0", i, z_state, z_rsp_valid); end
            @(negedge clk);
            checks++;
            if (z_state !== 2'd3 || z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0 || z_rsp_rdata !== t_exp[i])
                begin errors++; $display("FAIL zw_resp[%0d]: st=%0d vld=%b err=%b rd=%h, want 3 1 0 %h", i, z_state, z_rsp_valid, z_rsp_err, z_rsp_rdata, t_exp[i]); end
            @(negedge clk);
            checks++;
            if (z_state !== 2'd0 || z_rsp_valid !== 1'b0)
                begin errors++; $display("FAIL zw_idle[%0d]: st=%0d vld=%b, want 0 0", i, z_state, z_rsp_valid); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_store_load();
        test_byte_half();
        test_errors();
        test_range();
        test_back_to_back();
        test_abort();
        test_reset_in_resp();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
